zmips_fetch: RTL and testbench
==============================

ZMIPS_FETCH -- requirements
Module: zmips_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word-aligned address of the first fetched instruction after reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: i_addr  output  32  instruction memory address; always equals the internal PC.
REQ-006 Port: i_data  input  32  instruction word; valid combinationally in the same cycle as i_addr.
REQ-007 Port: i_rd  output  1  fetch strobe; high when i_data is captured at the next edge.
REQ-008 Port: redir_valid  input  1  branch/jump redirect request from the execute stage.
REQ-009 Port: redir_pc  input  32  redirect target; bits [1:0] are ignored.
REQ-010 Port: out_valid  output  1  head entry holds a valid instruction for decode.
REQ-011 Port: out_ready  input  1  decode accepts the head entry this cycle.
REQ-012 Port: out_instr  output  32  instruction word of the head entry (loaded into decode's IR).
REQ-013 Port: out_pc  output  32  fetch address of the head entry.

Function
REQ-014 The block SHALL hold a 2-entry in-order buffer of {pc, instr} pairs, with a 2-bit occupancy count (0..2).
REQ-015 out_valid SHALL equal (count != 0); out_instr and out_pc SHALL be driven from the head entry only, and SHALL be registered with no combinational path from i_data.
REQ-016 A pop SHALL occur when out_valid && out_ready.
REQ-017 i_rd SHALL be high when !redir_valid && (count < 2 || pop).
REQ-018 When i_rd is high, the block SHALL push {pc, i_data} at the edge and set pc <= pc + 4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 A push and a pop in the same cycle SHALL leave count unchanged. This includes the full case (count == 2), where the pushed entry becomes the tail.
REQ-020 Latency: an instruction fetched at address A SHALL appear at the head no earlier than the edge after i_addr == A. When the buffer is empty, out_valid SHALL rise exactly one cycle after the fetch.
REQ-021 When redir_valid is high, the block SHALL at the edge flush all entries (count <= 0), set pc <= {redir_pc[31:2], 2'b00}, and perform no push.
REQ-022 Redirect SHALL take priority over push and pop. A head accepted in the redirect cycle counts as delivered; no entry survives the flush.
REQ-023 Back-to-back redirects SHALL each retarget pc; the last one wins, and fetch resumes in the first cycle with redir_valid low.
REQ-024 When out_ready is held low, entries SHALL be held unchanged, no entry SHALL be lost or duplicated, and i_rd SHALL drop once count == 2.
REQ-025 i_addr[1:0] SHALL always be 2'b00.

Reset
REQ-026 While rst is high: pc = RESET_PC, count = 0, out_valid = 0, i_rd = 0, out_instr = 0, out_pc = 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries and any pending redirect, taking effect immediately (asynchronously).
REQ-028 The first fetch (i_addr = RESET_PC, i_rd = 1) SHALL occur in the first cycle after rst deasserts.

Structure
REQ-029 The shared package zmips_pkg SHALL hold RESET_PC_DEFAULT, INSTR_W = 32, ADDR_W = 32 and WORD_STRIDE = 4.
REQ-030 The buffer SHALL be a sub-module zmips_fetch_fifo: 2-deep, 64 bits wide, with push/pop/flush inputs and count/head outputs. PC and redirect logic SHALL stay in zmips_fetch.

Verification
REQ-031 Reset release, out_ready = 1, memory word[n] = n -> i_addr sequence 0, 4, 8, ...; out_pc/out_instr = (0, 0), (4, 1), (8, 2), one per cycle from cycle 2.
REQ-032 out_ready = 0 for 5 cycles after reset -> i_rd high for exactly 2 cycles, count = 2, head stays (0, 0); on release, heads 0, 4, 8 arrive in order with no gaps or duplicates.
REQ-033 redir_valid with redir_pc = 32'h0000_1003 while count = 2 -> next cycle out_valid = 0 and i_addr = 32'h0000_1000; one cycle later out_pc = 32'h0000_1000.
REQ-034 redir_valid together with out_valid && out_ready and count = 2 -> count = 0 after the edge, and no stale pc (e.g. 32'h8) appears later.
REQ-035 RESET_PC = 32'hFFFF_FFF8, free-running -> i_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-036 rst pulsed mid-stream with count = 2 -> out_valid = 0 immediately; first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/zmips_pkg.sv
// Shared constants and types for the zmips front end.
package zmips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] WORD_STRIDE      = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/zmips_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface zmips_fetch_if;
  import zmips_pkg::*;

  logic [ADDR_W-1:0]  i_addr;
  logic [INSTR_W-1:0] i_data;
  logic               i_rd;
  logic               redir_valid;
  logic [ADDR_W-1:0]  redir_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output i_addr, i_rd, out_valid, out_instr, out_pc,
    input  i_data, redir_valid, redir_pc, out_ready
  );

  modport slave (
    input  i_addr, i_rd, out_valid, out_instr, out_pc,
    output i_data, redir_valid, redir_pc, out_ready
  );

endinterface

// File: rtl/zmips_fetch_fifo.sv
// Two-entry in-order buffer of {pc, instr} pairs; head is read straight from storage flops.
module zmips_fetch_fifo
  import zmips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t [1:0] mem_q, mem_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               wr_ptr;
  logic               do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    // A full buffer may still accept a push when the head leaves in the same cycle.
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    // Tail slot is rd_ptr + count (mod 2); when full it is the slot being popped.
    wr_ptr  = rd_ptr_q ^ count_q[0];

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr] = push_data_i;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/zmips_fetch.sv
// Instruction fetch stage: PC sequencing, redirect handling and a 2-entry decode buffer.
module zmips_fetch
  import zmips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  zmips_fetch_if.master bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count;
  logic              pop;
  logic              fetch;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  always_comb begin
    pop   = (count != 2'd0) && bus.out_ready;
    // Redirect suppresses the fetch; reset gating keeps the strobe low while rst is held.
    fetch = !rst && !bus.redir_valid && ((count < 2'd2) || pop);

    push_entry.pc    = pc_q;
    push_entry.instr = bus.i_data;

    if (bus.redir_valid) begin
      pc_d = word_align(bus.redir_pc);
    end else if (fetch) begin
      pc_d = pc_q + WORD_STRIDE;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  zmips_fetch_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fetch),
    .pop_i       (pop),
    .flush_i     (bus.redir_valid),
    .push_data_i (push_entry),
    .count_o     (count),
    .head_o      (head)
  );

  assign bus.i_addr    = pc_q;
  assign bus.i_rd      = fetch;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_zmips_fetch.sv
// Bench for zmips_fetch: queue-based reference model, directed scenarios and random traffic.
module tb_zmips_fetch;
  import zmips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  zmips_fetch_if f ();
  zmips_fetch_if w ();

  // Memory word at byte address A holds A/4.
  assign f.i_data = f.i_addr >> 2;
  assign w.i_data = w.i_addr >> 2;

  zmips_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (f)
  );

  zmips_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_qpc[$];
  logic [31:0] m_qins[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_rd();
    return !f.redir_valid &&
           ((m_qpc.size() < 2) || ((m_qpc.size() != 0) && f.out_ready));
  endfunction

  // Reference model: a queue of fetched entries, updated at each active edge.
  initial begin
    m_pc = 32'h0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_qpc.delete();
        m_qins.delete();
        m_pc = 32'h0;
      end else begin
        logic pop, rd;
        pop = (m_qpc.size() != 0) && f.out_ready;
        rd  = exp_rd();
        if (f.redir_valid) begin
          m_qpc.delete();
          m_qins.delete();
          m_pc = f.redir_pc & 32'hFFFF_FFFC;
        end else begin
          if (pop) begin
            void'(m_qpc.pop_front());
            void'(m_qins.pop_front());
          end
          if (rd) begin
            m_qpc.push_back(m_pc);
            m_qins.push_back(m_pc >> 2);
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Compare process: every falling edge, DUT against model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_i_addr", f.i_addr, 32'h0);
        chk("rst_i_rd", {31'b0, f.i_rd}, 32'h0);
        chk("rst_out_valid", {31'b0, f.out_valid}, 32'h0);
        chk("rst_out_pc", f.out_pc, 32'h0);
        chk("rst_out_instr", f.out_instr, 32'h0);
        chk("rst_wrap_i_addr", w.i_addr, 32'hFFFF_FFF8);
      end else begin
        chk("i_addr", f.i_addr, m_pc);
        chk("i_rd", {31'b0, f.i_rd}, {31'b0, exp_rd()});
        chk("out_valid", {31'b0, f.out_valid}, {31'b0, m_qpc.size() != 0});
        if (m_qpc.size() != 0) begin
          chk("out_pc", f.out_pc, m_qpc[0]);
          chk("out_instr", f.out_instr, m_qins[0]);
        end
      end
    end
  end

  initial begin
    int rd_cnt;
    logic [31:0] wrap_exp[4];
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    f.out_ready   = 1'b0;
    f.redir_valid = 1'b0;
    f.redir_pc    = 32'h0;
    w.out_ready   = 1'b1;
    w.redir_valid = 1'b0;
    w.redir_pc    = 32'h0;

    // Reset release, free-running stream.
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    f.out_ready = 1'b1;
    #1;
    chk("first_addr", f.i_addr, 32'h0);
    chk("first_rd", {31'b0, f.i_rd}, 32'h1);
    chk("first_valid", {31'b0, f.out_valid}, 32'h0);
    chk("wrap_addr", w.i_addr, wrap_exp[0]);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("seq_valid", {31'b0, f.out_valid}, 32'h1);
      chk("seq_pc", f.out_pc, 32'(4 * (k - 1)));
      chk("seq_instr", f.out_instr, 32'(k - 1));
      chk("seq_addr", f.i_addr, 32'(4 * k));
      if (k <= 3) chk("wrap_addr", w.i_addr, wrap_exp[k]);
    end

    // Fill to two entries, then asynchronous reset mid-stream.
    #1 f.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("full_valid", {31'b0, f.out_valid}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, f.out_valid}, 32'h0);
    chk("async_rst_addr", f.i_addr, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    rd_cnt = int'(f.i_rd);
    chk("rst_refetch_addr", f.i_addr, 32'h0);

    // Stall: fetch strobe for exactly two cycles, head held.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rd_cnt += int'(f.i_rd);
    end
    chk("stall_rd_cycles", 32'(rd_cnt), 32'd2);
    chk("stall_head_pc", f.out_pc, 32'h0);
    chk("stall_head_instr", f.out_instr, 32'h0);
    #1 f.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("drain_pc", f.out_pc, 32'(4 * k));
    end

    // Redirect while full.
    #1 f.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 f.redir_valid = 1'b1;
    f.redir_pc = 32'h0000_1003;
    @(negedge clk);
    chk("redir_valid_drop", {31'b0, f.out_valid}, 32'h0);
    chk("redir_addr", f.i_addr, 32'h0000_1000);
    #1 f.redir_valid = 1'b0;
    @(negedge clk);
    chk("redir_head_pc", f.out_pc, 32'h0000_1000);
    chk("redir_head_instr", f.out_instr, 32'h0000_0400);

    // Redirect coinciding with a pop while full.
    @(negedge clk);
    #1 f.redir_valid = 1'b1;
    f.redir_pc  = 32'h0000_2000;
    f.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'b0, f.out_valid}, 32'h0);
    chk("flush_addr", f.i_addr, 32'h0000_2000);
    #1 f.redir_valid = 1'b0;
    @(negedge clk);
    chk("flush_head0", f.out_pc, 32'h0000_2000);
    @(negedge clk);
    chk("flush_head1", f.out_pc, 32'h0000_2004);

    // Random traffic with back-to-back redirects and occasional reset pulses.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      #1;
      rst           = ($urandom_range(99) == 0);
      f.out_ready   = ($urandom_range(3) != 0);
      f.redir_valid = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0) begin
        f.redir_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      end else begin
        f.redir_pc = $urandom;
      end
    end
    #1 rst = 1'b0;
    f.redir_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
